// File: rtl/exec_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_unit_pkg
//  Description : Shared opcode/funct encodings, display tap word indices and
//                the link register number for the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_unit_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_LUI   = 6'd3;
  localparam logic [5:0] OP_ANDI  = 6'd4;
  localparam logic [5:0] OP_ORI   = 6'd5;
  localparam logic [5:0] OP_XORI  = 6'd6;
  localparam logic [5:0] OP_LW    = 6'd16;
  localparam logic [5:0] OP_LH    = 6'd18;
  localparam logic [5:0] OP_LB    = 6'd20;
  localparam logic [5:0] OP_SW    = 6'd24;
  localparam logic [5:0] OP_SH    = 6'd26;
  localparam logic [5:0] OP_SB    = 6'd28;
  localparam logic [5:0] OP_BEQ   = 6'd32;
  localparam logic [5:0] OP_BNE   = 6'd33;
  localparam logic [5:0] OP_BLT   = 6'd34;
  localparam logic [5:0] OP_BGE   = 6'd35;
  localparam logic [5:0] OP_J     = 6'd40;
  localparam logic [5:0] OP_JAL   = 6'd41;
  localparam logic [5:0] OP_JR    = 6'd42;
  localparam logic [5:0] OP_HALT  = 6'd63;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd2;
  localparam logic [5:0] FN_AND = 6'd8;
  localparam logic [5:0] FN_OR  = 6'd9;
  localparam logic [5:0] FN_XOR = 6'd10;
  localparam logic [5:0] FN_NOR = 6'd11;
  localparam logic [5:0] FN_SLL = 6'd16;
  localparam logic [5:0] FN_SRL = 6'd17;
  localparam logic [5:0] FN_SRA = 6'd18;

  // Word indices watched by the self-check display
  localparam logic [7:0] TAP_WORD_DM532 = 8'd133;
  localparam logic [7:0] TAP_WORD_DM900 = 8'd225;
  localparam logic [7:0] TAP_WORD_DM576 = 8'd144;

  // Link register written by jal
  localparam logic [4:0] LINK_REG = 5'd31;

endpackage : exec_unit_pkg
`default_nettype wire

// File: rtl/exec_unit_byte_lane_ram.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_ram
//  Description : One 256x8 byte lane of the data memory. Asynchronous read,
//                synchronous write, asynchronous clear of every location.
//                Also exposes the three display tap bytes of this lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_ram
  import exec_unit_pkg::*;
(
  input  logic       sysclk,
  input  logic       cpu_resetn,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic [7:0] tap_dm532,
  output logic [7:0] tap_dm900,
  output logic [7:0] tap_dm576
);

  logic [7:0] r_mem [0:255];

  // Storage: whole lane cleared while reset is asserted, byte write otherwise
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      for (int i = 0; i < 256; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata     = r_mem[addr];
  assign tap_dm532 = r_mem[TAP_WORD_DM532];
  assign tap_dm900 = r_mem[TAP_WORD_DM900];
  assign tap_dm576 = r_mem[TAP_WORD_DM576];

endmodule : byte_lane_ram
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : exec_unit
//  Description : Execute stage: ALU, effective address, destination register,
//                1 KiB byte-laned data memory, load extraction and result
//                select. Fully combinational except for memory writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_unit
  import exec_unit_pkg::*;
(
  input  logic        sysclk,
  input  logic        cpu_resetn,
  input  logic [31:0] pc,
  input  logic [5:0]  op,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [10:0] aux,
  input  logic [31:0] os,
  input  logic [31:0] ot,
  input  logic [31:0] imm_dpl,
  output logic [4:0]  wreg,
  output logic [31:0] result,
  output logic [31:0] dm532,
  output logic [31:0] dm900,
  output logic [31:0] dm576
);

  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic [31:0] w_ea;
  logic [31:0] w_zimm;
  logic [31:0] w_alu;
  logic [4:0]  w_wreg;
  logic [3:0]  w_lane_we;
  logic        w_is_load;
  logic        w_is_store;
  logic [31:0] w_word;
  logic [31:0] w_load;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic        r_wr_armed;

  logic [7:0]  w_lane_rd    [4];
  logic [7:0]  w_lane_t532  [4];
  logic [7:0]  w_lane_t900  [4];
  logic [7:0]  w_lane_t576  [4];

  assign w_funct = aux[5:0];
  assign w_shamt = aux[10:6];
  assign w_ea    = os + imm_dpl;
  assign w_zimm  = {16'h0000, imm_dpl[15:0]};

  // Write arming: stays low through the first edge after reset release so a
  // store sitting in the release cycle is dropped
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_wr_armed <= 1'b0;
    end else begin
      r_wr_armed <= 1'b1;
    end
  end

  // Decode and ALU: for stores the ALU output is the replicated write data
  always_comb begin
    w_alu      = 32'h0;
    w_wreg     = 5'd0;
    w_lane_we  = 4'b0000;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    case (op)
      OP_RTYPE: begin
        w_wreg = rd;
        case (w_funct)
          FN_ADD:  w_alu = os + ot;
          FN_SUB:  w_alu = os - ot;
          FN_AND:  w_alu = os & ot;
          FN_OR:   w_alu = os | ot;
          FN_XOR:  w_alu = os ^ ot;
          FN_NOR:  w_alu = ~(os | ot);
          FN_SLL:  w_alu = ot << w_shamt;
          FN_SRL:  w_alu = ot >> w_shamt;
          FN_SRA:  w_alu = $unsigned($signed(ot) >>> w_shamt);
          default: begin
            w_alu  = 32'h0;
            w_wreg = 5'd0;
          end
        endcase
      end
      OP_ADDI: begin w_alu = os + imm_dpl;              w_wreg = rt; end
      OP_LUI:  begin w_alu = {imm_dpl[15:0], 16'h0000}; w_wreg = rt; end
      OP_ANDI: begin w_alu = os & w_zimm;               w_wreg = rt; end
      OP_ORI:  begin w_alu = os | w_zimm;               w_wreg = rt; end
      OP_XORI: begin w_alu = os ^ w_zimm;               w_wreg = rt; end
      OP_LW, OP_LH, OP_LB: begin
        w_alu     = w_ea;
        w_wreg    = rt;
        w_is_load = 1'b1;
      end
      OP_SW: begin
        w_alu      = ot;
        w_lane_we  = 4'b1111;
        w_is_store = 1'b1;
      end
      OP_SH: begin
        w_alu      = {2{ot[15:0]}};
        w_lane_we  = w_ea[1] ? 4'b1100 : 4'b0011;
        w_is_store = 1'b1;
      end
      OP_SB: begin
        w_alu      = {4{ot[7:0]}};
        w_lane_we  = 4'b0001 << w_ea[1:0];
        w_is_store = 1'b1;
      end
      OP_JAL: begin
        w_alu  = pc + 32'd4;
        w_wreg = LINK_REG;
      end
      default: begin
        w_alu  = 32'h0;
        w_wreg = 5'd0;
      end
    endcase
  end

  // Four byte lanes; lane k holds byte offset k of each word
  generate
    for (genvar k = 0; k < 4; k++) begin : g_lane
      byte_lane_ram u_lane (
        .sysclk     (sysclk),
        .cpu_resetn (cpu_resetn),
        .we         (w_lane_we[k] & r_wr_armed),
        .addr       (w_ea[9:2]),
        .wdata      (w_alu[8*k +: 8]),
        .rdata      (w_lane_rd[k]),
        .tap_dm532  (w_lane_t532[k]),
        .tap_dm900  (w_lane_t900[k]),
        .tap_dm576  (w_lane_t576[k])
      );
    end
  endgenerate

  assign w_word = {w_lane_rd[3], w_lane_rd[2], w_lane_rd[1], w_lane_rd[0]};
  assign dm532  = {w_lane_t532[3], w_lane_t532[2], w_lane_t532[1], w_lane_t532[0]};
  assign dm900  = {w_lane_t900[3], w_lane_t900[2], w_lane_t900[1], w_lane_t900[0]};
  assign dm576  = {w_lane_t576[3], w_lane_t576[2], w_lane_t576[1], w_lane_t576[0]};

  // Load extraction: pick halfword/byte by address and sign-extend
  always_comb begin
    w_half = w_ea[1] ? w_word[31:16] : w_word[15:0];
    w_byte = w_word[7:0];
    case (w_ea[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_load = w_word;
    case (op)
      OP_LH:   w_load = {{16{w_half[15]}}, w_half};
      OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      default: w_load = w_word;
    endcase
  end

  // Result select: load data, zero for stores, ALU otherwise
  always_comb begin
    if (w_is_load) begin
      result = w_load;
    end else if (w_is_store) begin
      result = 32'h0;
    end else begin
      result = w_alu;
    end
  end

  assign wreg = w_wreg;

endmodule : exec_unit
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_unit
//  Description : Self-checking bench for exec_unit. Each issued instruction
//                pushes its expected wreg/result onto a scoreboard which is
//                popped and compared on the following falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_unit;

  logic        sysclk;
  logic        cpu_resetn;
  logic [31:0] pc;
  logic [5:0]  op;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [10:0] aux;
  logic [31:0] os;
  logic [31:0] ot;
  logic [31:0] imm_dpl;
  logic [4:0]  wreg;
  logic [31:0] result;
  logic [31:0] dm532;
  logic [31:0] dm900;
  logic [31:0] dm576;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [4:0]  wreg;
    logic [31:0] result;
  } exp_t;

  exp_t sb_q[$];

  exec_unit dut (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .pc         (pc),
    .op         (op),
    .rt         (rt),
    .rd         (rd),
    .aux        (aux),
    .os         (os),
    .ot         (ot),
    .imm_dpl    (imm_dpl),
    .wreg       (wreg),
    .result     (result),
    .dm532      (dm532),
    .dm900      (dm900),
    .dm576      (dm576)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one instruction for one cycle and record its expected outputs
  task automatic issue(input string tag, input logic [5:0] o, input logic [4:0] t,
                       input logic [4:0] d, input logic [10:0] a, input logic [31:0] s,
                       input logic [31:0] tv, input logic [31:0] im, input logic [31:0] p,
                       input logic [4:0] ew, input logic [31:0] er);
    exp_t e;
    @(posedge sysclk);
    #1;
    op = o; rt = t; rd = d; aux = a; os = s; ot = tv; imm_dpl = im; pc = p;
    e.tag = tag; e.wreg = ew; e.result = er;
    sb_q.push_back(e);
  endtask

  // Scoreboard drain: compare the instruction issued this cycle
  always @(negedge sysclk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, ".wreg"}, {27'd0, wreg}, {27'd0, e.wreg});
      check({e.tag, ".result"}, result, e.result);
    end
  end

  initial begin
    cpu_resetn = 1'b0;
    op = 6'd63; rt = '0; rd = '0; aux = '0; os = '0; ot = '0; imm_dpl = '0; pc = '0;
    repeat (2) @(posedge sysclk);
    #1;
    check("rst.dm532", dm532, 32'h0);
    check("rst.dm900", dm900, 32'h0);
    check("rst.dm576", dm576, 32'h0);
    @(negedge sysclk);
    cpu_resetn = 1'b1;

    // R-type
    issue("sub",  6'd0, 5'd0, 5'd3, {5'd0, 6'd2},  32'd7, 32'd5, 32'h0, 32'h0, 5'd3, 32'd2);
    issue("sra",  6'd0, 5'd0, 5'd4, {5'd4, 6'd18}, 32'h0, 32'h80000000, 32'h0, 32'h0, 5'd4, 32'hF8000000);
    issue("nor",  6'd0, 5'd0, 5'd5, {5'd0, 6'd11}, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 32'hFFFFFFFF);
    issue("add",  6'd0, 5'd0, 5'd6, {5'd0, 6'd0},  32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, 5'd6, 32'd1);
    issue("sll",  6'd0, 5'd0, 5'd7, {5'd31, 6'd16}, 32'h0, 32'd1, 32'h0, 32'h0, 5'd7, 32'h80000000);
    issue("srl",  6'd0, 5'd0, 5'd7, {5'd31, 6'd17}, 32'h0, 32'h80000000, 32'h0, 32'h0, 5'd7, 32'd1);
    issue("xor",  6'd0, 5'd0, 5'd8, {5'd0, 6'd10}, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 5'd8, 32'h0FF0);
    issue("and",  6'd0, 5'd0, 5'd8, {5'd0, 6'd8},  32'hF0F0, 32'hFF00, 32'h0, 32'h0, 5'd8, 32'hF000);
    issue("or",   6'd0, 5'd0, 5'd8, {5'd0, 6'd9},  32'hF0F0, 32'hFF00, 32'h0, 32'h0, 5'd8, 32'hFFF0);
    issue("badfn",6'd0, 5'd0, 5'd9, {5'd0, 6'd63}, 32'd1, 32'd1, 32'h0, 32'h0, 5'd0, 32'h0);

    // Immediates, jumps, undefined
    issue("lui",  6'd3, 5'd8, 5'd0, 11'd0, 32'h0, 32'h0, 32'hFFFF8001, 32'h0, 5'd8, 32'h80010000);
    issue("ori",  6'd5, 5'd9, 5'd0, 11'd0, 32'h0, 32'h0, 32'hFFFF8000, 32'h0, 5'd9, 32'h00008000);
    issue("andi", 6'd4, 5'd9, 5'd0, 11'd0, 32'hFFFFFFFF, 32'h0, 32'hFFFF8000, 32'h0, 5'd9, 32'h00008000);
    issue("xori", 6'd6, 5'd9, 5'd0, 11'd0, 32'hFFFF0000, 32'h0, 32'hFFFF00FF, 32'h0, 5'd9, 32'hFFFF00FF);
    issue("addi", 6'd1, 5'd2, 5'd0, 11'd0, 32'd10, 32'h0, 32'hFFFFFFFF, 32'h0, 5'd2, 32'd9);
    issue("jal",  6'd41, 5'd3, 5'd4, 11'd0, 32'h0, 32'h0, 32'h0, 32'h40, 5'd31, 32'h44);
    issue("j",    6'd40, 5'd3, 5'd4, 11'd0, 32'h0, 32'h0, 32'h0, 32'h40, 5'd0, 32'h0);
    issue("undef",6'd7, 5'd3, 5'd4, 11'd0, 32'd1, 32'd1, 32'd1, 32'h40, 5'd0, 32'h0);

    // Word store/load and address wrap
    issue("sw",   6'd24, 5'd2, 5'd0, 11'd0, 32'd500, 32'h315, 32'd32, 32'h0, 5'd0, 32'h0);
    issue("lw",   6'd16, 5'd10, 5'd0, 11'd0, 32'd500, 32'h0, 32'd32, 32'h0, 5'd10, 32'h315);
    check("sw.dm532", dm532, 32'h315);
    issue("lw_off",6'd16, 5'd10, 5'd0, 11'd0, 32'd503, 32'h0, 32'd32, 32'h0, 5'd10, 32'h315);
    issue("sw_wrap",6'd24, 5'd2, 5'd0, 11'd0, 32'd1556, 32'hDEADBEEF, 32'd0, 32'h0, 5'd0, 32'h0);
    issue("lw_wrap",6'd16, 5'd11, 5'd0, 11'd0, 32'd500, 32'h0, 32'd32, 32'h0, 5'd11, 32'hDEADBEEF);
    check("wrap.dm532", dm532, 32'hDEADBEEF);

    // Byte store, byte/half loads
    issue("sb",   6'd28, 5'd2, 5'd0, 11'd0, 32'd577, 32'h12345680, 32'd0, 32'h0, 5'd0, 32'h0);
    issue("lb",   6'd20, 5'd12, 5'd0, 11'd0, 32'd577, 32'h0, 32'd0, 32'h0, 5'd12, 32'hFFFFFF80);
    check("sb.dm576", dm576, 32'h00008000);
    issue("lh",   6'd18, 5'd12, 5'd0, 11'd0, 32'd576, 32'h0, 32'd0, 32'h0, 5'd12, 32'hFFFF8000);
    issue("lb0",  6'd20, 5'd12, 5'd0, 11'd0, 32'd576, 32'h0, 32'd0, 32'h0, 5'd12, 32'h0);

    // Halfword store into upper half, then a byte into lane 0
    issue("sh",   6'd26, 5'd2, 5'd0, 11'd0, 32'd902, 32'hABCD1234, 32'd0, 32'h0, 5'd0, 32'h0);
    issue("lw900",6'd16, 5'd13, 5'd0, 11'd0, 32'd900, 32'h0, 32'd0, 32'h0, 5'd13, 32'h12340000);
    check("sh.dm900", dm900, 32'h12340000);
    issue("sb900",6'd28, 5'd2, 5'd0, 11'd0, 32'd900, 32'h00000077, 32'd0, 32'h0, 5'd0, 32'h0);
    issue("lh900",6'd18, 5'd13, 5'd0, 11'd0, 32'd900, 32'h0, 32'd0, 32'h0, 5'd13, 32'h00000077);
    check("sb.dm900", dm900, 32'h12340077);
    issue("lb903",6'd20, 5'd13, 5'd0, 11'd0, 32'd903, 32'h0, 32'd0, 32'h0, 5'd13, 32'h00000012);
    issue("lh902",6'd18, 5'd13, 5'd0, 11'd0, 32'd902, 32'h0, 32'd0, 32'h0, 5'd13, 32'h00001234);

    // Asynchronous reset clears memory; stores under reset and in the
    // release cycle are dropped
    @(negedge sysclk);
    cpu_resetn = 1'b0;
    #1;
    check("arst.dm532", dm532, 32'h0);
    check("arst.dm900", dm900, 32'h0);
    check("arst.dm576", dm576, 32'h0);
    issue("sw_rst", 6'd24, 5'd2, 5'd0, 11'd0, 32'd500, 32'h5555, 32'd32, 32'h0, 5'd0, 32'h0);
    issue("sw_rel", 6'd24, 5'd2, 5'd0, 11'd0, 32'd500, 32'h6666, 32'd32, 32'h0, 5'd0, 32'h0);
    @(negedge sysclk);
    cpu_resetn = 1'b1;
    issue("lw_rel", 6'd16, 5'd14, 5'd0, 11'd0, 32'd500, 32'h0, 32'd32, 32'h0, 5'd14, 32'h0);
    check("rel.dm532", dm532, 32'h0);
    issue("sw_ok",  6'd24, 5'd2, 5'd0, 11'd0, 32'd500, 32'h7777, 32'd32, 32'h0, 5'd0, 32'h0);
    issue("lw_ok",  6'd16, 5'd14, 5'd0, 11'd0, 32'd500, 32'h0, 32'd32, 32'h0, 5'd14, 32'h7777);
    check("ok.dm532", dm532, 32'h7777);

    repeat (2) @(negedge sysclk);
    #1;
    check("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_exec_unit
`default_nettype wire
